// File: rtl/bp_me_nonsynth_pkg.sv
// Shared types for the mock LCE responder: message formats, coherence states, shadow entry.
package bp_me_nonsynth_pkg;

    localparam int unsigned paddr_width_p         = 40;
    localparam int unsigned lce_id_width_p        = 4;
    localparam int unsigned cce_id_width_p        = 4;
    localparam int unsigned lce_assoc_p           = 8;
    localparam int unsigned lce_sets_p            = 64;
    localparam int unsigned cce_block_width_p     = 512;
    localparam int unsigned block_offset_width_lp = $clog2(cce_block_width_p / 8);
    localparam int unsigned lg_sets_lp            = $clog2(lce_sets_p);
    localparam int unsigned way_id_width_lp       = $clog2(lce_assoc_p);
    localparam int unsigned tag_width_lp          = paddr_width_p - lg_sets_lp - block_offset_width_lp;

    typedef enum logic [3:0] {
        e_lce_cmd_sync             = 4'd0,
        e_lce_cmd_set_clear        = 4'd1,
        e_lce_cmd_invalidate_tag   = 4'd2,
        e_lce_cmd_set_tag          = 4'd3,
        e_lce_cmd_set_tag_wakeup   = 4'd4,
        e_lce_cmd_data             = 4'd5,
        e_lce_cmd_writeback        = 4'd6
    } bp_lce_cmd_type_e;

    typedef enum logic [2:0] {
        e_lce_cce_sync_ack     = 3'd0,
        e_lce_cce_inv_ack      = 3'd1,
        e_lce_cce_coh_ack      = 3'd2,
        e_lce_cce_resp_wb      = 3'd3,
        e_lce_cce_resp_null_wb = 3'd4
    } bp_lce_cce_resp_type_e;

    typedef enum logic [2:0] {
        e_COH_I = 3'd0,
        e_COH_S = 3'd1,
        e_COH_E = 3'd2,
        e_COH_F = 3'd3,
        e_COH_O = 3'd4,
        e_COH_M = 3'd5
    } bp_coh_states_e;

    typedef enum logic [2:0] {
        e_size_1B  = 3'd0,
        e_size_2B  = 3'd1,
        e_size_4B  = 3'd2,
        e_size_8B  = 3'd3,
        e_size_16B = 3'd4,
        e_size_32B = 3'd5,
        e_size_64B = 3'd6
    } bp_mem_size_e;

    typedef struct packed {
        bp_lce_cmd_type_e            msg_type;
        logic [way_id_width_lp-1:0]  way_id;
        bp_coh_states_e              state;
        logic [paddr_width_p-1:0]    addr;
        logic [cce_id_width_p-1:0]   src_id;
        logic [lce_id_width_p-1:0]   dst_id;
    } bp_lce_cmd_header_s;

    typedef struct packed {
        bp_lce_cmd_header_s             header;
        logic [cce_block_width_p-1:0]   data;
    } bp_lce_cmd_s;

    typedef struct packed {
        bp_lce_cce_resp_type_e       msg_type;
        bp_mem_size_e                size;
        logic [paddr_width_p-1:0]    addr;
        logic [lce_id_width_p-1:0]   src_id;
        logic [cce_id_width_p-1:0]   dst_id;
    } bp_lce_cce_resp_header_s;

    typedef struct packed {
        bp_lce_cce_resp_header_s        header;
        logic [cce_block_width_p-1:0]   data;
    } bp_lce_cce_resp_s;

    typedef enum logic [0:0] {
        e_ready = 1'b0,
        e_send  = 1'b1
    } mock_state_e;

    typedef struct packed {
        logic [tag_width_lp-1:0] tag;
        bp_coh_states_e          state;
        logic                    dirty;
    } shadow_entry_s;

    // Set index carried in a physical address
    function automatic logic [lg_sets_lp-1:0] addr_set(input logic [paddr_width_p-1:0] addr);
        return addr[block_offset_width_lp +: lg_sets_lp];
    endfunction

    // Tag carried in a physical address
    function automatic logic [tag_width_lp-1:0] addr_tag(input logic [paddr_width_p-1:0] addr);
        return addr[paddr_width_p-1 -: tag_width_lp];
    endfunction

endpackage

// File: rtl/bp_me_nonsynth_mock_lce_array.sv
// Shadow tag/state/dirty/data array: one write port, one set-clear port, combinational read.
module bp_me_nonsynth_mock_lce_array
    import bp_me_nonsynth_pkg::*;
#(
    parameter int unsigned sets_p        = lce_sets_p,
    parameter int unsigned assoc_p       = lce_assoc_p,
    parameter int unsigned block_width_p = cce_block_width_p,
    localparam int unsigned lg_sets_w    = $clog2(sets_p),
    localparam int unsigned lg_assoc_w   = $clog2(assoc_p)
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_wr_v,
    input  logic [lg_sets_w-1:0]     i_wr_set,
    input  logic [lg_assoc_w-1:0]    i_wr_way,
    input  shadow_entry_s            i_wr_entry,
    input  logic                     i_wr_data_v,
    input  logic [block_width_p-1:0] i_wr_data,
    input  logic                     i_clr_v,
    input  logic [lg_sets_w-1:0]     i_clr_set,
    input  logic [lg_sets_w-1:0]     i_rd_set,
    input  logic [lg_assoc_w-1:0]    i_rd_way,
    output shadow_entry_s            o_rd_entry,
    output logic [block_width_p-1:0] o_rd_data
);

    shadow_entry_s            r_meta [sets_p][assoc_p];
    logic [block_width_p-1:0] r_data [sets_p][assoc_p];

    // Metadata: reset to invalid/clean/tag 0; set-clear invalidates a whole set, keeping tags
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int s = 0; s < int'(sets_p); s++) begin
                for (int w = 0; w < int'(assoc_p); w++) begin
                    r_meta[s][w] <= '0;
                end
            end
        end else begin
            if (i_clr_v) begin
                for (int w = 0; w < int'(assoc_p); w++) begin
                    r_meta[i_clr_set][w].state <= e_COH_I;
                    r_meta[i_clr_set][w].dirty <= 1'b0;
                end
            end
            if (i_wr_v) begin
                r_meta[i_wr_set][i_wr_way] <= i_wr_entry;
            end
        end
    end

    // Block data storage; contents are meaningless until written
    always_ff @(posedge i_clk) begin
        if (i_wr_data_v) begin
            r_data[i_wr_set][i_wr_way] <= i_wr_data;
        end
    end

    assign o_rd_entry = r_meta[i_rd_set][i_rd_way];
    assign o_rd_data  = r_data[i_rd_set][i_rd_way];

endmodule

// File: rtl/bp_me_nonsynth_mock_lce_responder.sv
// Mock LCE: consumes CCE commands, tracks a shadow array, returns one response at a time.
module bp_me_nonsynth_mock_lce_responder
    import bp_me_nonsynth_pkg::*;
#(
    parameter int unsigned sets_p        = lce_sets_p,
    parameter int unsigned assoc_p       = lce_assoc_p,
    parameter int unsigned block_width_p = cce_block_width_p
) (
    input  logic                      clk_i,
    input  logic                      reset_n_i,
    input  logic [lce_id_width_p-1:0] lce_id_i,
    input  bp_lce_cmd_s               lce_cmd_i,
    input  logic                      lce_cmd_v_i,
    output logic                      lce_cmd_yumi_o,
    output bp_lce_cce_resp_s          lce_resp_o,
    output logic                      lce_resp_v_o,
    input  logic                      lce_resp_ready_i,
    output logic                      error_o,
    output logic [31:0]               cmd_count_o
);

    mock_state_e             r_state, w_state_nxt;
    bp_lce_cce_resp_s        r_resp, w_resp_nxt;
    logic                    r_resp_v, w_resp_v_nxt;
    logic                    r_error, w_error_nxt;
    logic [31:0]             r_count, w_count_nxt;

    logic                    w_yumi;
    logic [lg_sets_lp-1:0]   w_set;
    shadow_entry_s           w_rd_entry, w_wr_entry;
    logic [block_width_p-1:0] w_rd_data;
    logic                    w_wr_v, w_wr_data_v, w_clr_v;
    logic                    w_resp_queue;
    bp_lce_cce_resp_type_e   w_resp_type;
    bp_mem_size_e            w_resp_size;
    logic [block_width_p-1:0] w_resp_data;

    assign w_set = addr_set(lce_cmd_i.header.addr);

    bp_me_nonsynth_mock_lce_array #(
        .sets_p        (sets_p),
        .assoc_p       (assoc_p),
        .block_width_p (block_width_p)
    ) u_array (
        .i_clk       (clk_i),
        .i_rst_n     (reset_n_i),
        .i_wr_v      (w_wr_v),
        .i_wr_set    (w_set),
        .i_wr_way    (lce_cmd_i.header.way_id),
        .i_wr_entry  (w_wr_entry),
        .i_wr_data_v (w_wr_data_v),
        .i_wr_data   (lce_cmd_i.data),
        .i_clr_v     (w_clr_v),
        .i_clr_set   (w_set),
        .i_rd_set    (w_set),
        .i_rd_way    (lce_cmd_i.header.way_id),
        .o_rd_entry  (w_rd_entry),
        .o_rd_data   (w_rd_data)
    );

    // Next-state, array update and response formation
    always_comb begin
        w_state_nxt  = r_state;
        w_resp_nxt   = r_resp;
        w_resp_v_nxt = r_resp_v;
        w_error_nxt  = r_error;
        w_count_nxt  = r_count;
        w_yumi       = 1'b0;
        w_wr_v       = 1'b0;
        w_wr_entry   = w_rd_entry;
        w_wr_data_v  = 1'b0;
        w_clr_v      = 1'b0;
        w_resp_queue = 1'b0;
        w_resp_type  = e_lce_cce_sync_ack;
        w_resp_size  = e_size_1B;
        w_resp_data  = '0;

        case (r_state)
            e_ready: begin
                w_yumi = lce_cmd_v_i;
                if (lce_cmd_v_i) begin
                    w_count_nxt = r_count + 32'd1;
                    if (lce_cmd_i.header.dst_id != lce_id_i) begin
                        w_error_nxt = 1'b1;
                    end else begin
                        case (lce_cmd_i.header.msg_type)
                            e_lce_cmd_sync: begin
                                w_resp_queue = 1'b1;
                                w_resp_type  = e_lce_cce_sync_ack;
                            end
                            e_lce_cmd_set_clear: begin
                                w_clr_v = 1'b1;
                            end
                            e_lce_cmd_invalidate_tag: begin
                                w_wr_v           = 1'b1;
                                w_wr_entry.state = e_COH_I;
                                w_wr_entry.dirty = 1'b0;
                                w_resp_queue     = 1'b1;
                                w_resp_type      = e_lce_cce_inv_ack;
                            end
                            e_lce_cmd_set_tag, e_lce_cmd_set_tag_wakeup: begin
                                w_wr_v           = 1'b1;
                                w_wr_entry.tag   = addr_tag(lce_cmd_i.header.addr);
                                w_wr_entry.state = lce_cmd_i.header.state;
                                w_wr_entry.dirty = 1'b0;
                                w_resp_queue     = (lce_cmd_i.header.msg_type == e_lce_cmd_set_tag);
                                w_resp_type      = e_lce_cce_coh_ack;
                            end
                            e_lce_cmd_data: begin
                                w_wr_v           = 1'b1;
                                w_wr_data_v      = 1'b1;
                                w_wr_entry.tag   = addr_tag(lce_cmd_i.header.addr);
                                w_wr_entry.state = lce_cmd_i.header.state;
                                w_wr_entry.dirty = (lce_cmd_i.header.state == e_COH_M);
                                w_resp_queue     = 1'b1;
                                w_resp_type      = e_lce_cce_coh_ack;
                            end
                            e_lce_cmd_writeback: begin
                                w_resp_queue = 1'b1;
                                if (w_rd_entry.dirty) begin
                                    w_wr_v           = 1'b1;
                                    w_wr_entry.dirty = 1'b0;
                                    w_resp_type      = e_lce_cce_resp_wb;
                                    w_resp_size      = e_size_64B;
                                    w_resp_data      = w_rd_data;
                                end else begin
                                    w_resp_type      = e_lce_cce_resp_null_wb;
                                end
                            end
                            default: begin
                                w_error_nxt = 1'b1;
                            end
                        endcase
                    end

                    if (w_resp_queue) begin
                        w_resp_nxt.header.msg_type = w_resp_type;
                        w_resp_nxt.header.size     = w_resp_size;
                        w_resp_nxt.header.addr     = lce_cmd_i.header.addr;
                        w_resp_nxt.header.src_id   = lce_id_i;
                        w_resp_nxt.header.dst_id   = lce_cmd_i.header.src_id;
                        w_resp_nxt.data            = w_resp_data;
                        w_resp_v_nxt               = 1'b1;
                        w_state_nxt                = e_send;
                    end
                end
            end
            e_send: begin
                if (lce_resp_ready_i) begin
                    w_resp_v_nxt = 1'b0;
                    w_state_nxt  = e_ready;
                end
            end
            default: begin
                w_resp_v_nxt = 1'b0;
                w_state_nxt  = e_ready;
            end
        endcase
    end

    // State and output registers; reset drops any pending response at once
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_state  <= e_ready;
            r_resp   <= '0;
            r_resp_v <= 1'b0;
            r_error  <= 1'b0;
            r_count  <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_resp   <= w_resp_nxt;
            r_resp_v <= w_resp_v_nxt;
            r_error  <= w_error_nxt;
            r_count  <= w_count_nxt;
        end
    end

    assign lce_cmd_yumi_o = w_yumi;
    assign lce_resp_o     = r_resp;
    assign lce_resp_v_o   = r_resp_v;
    assign error_o        = r_error;
    assign cmd_count_o    = r_count;

endmodule

// File: tb/tb_bp_me_nonsynth_mock_lce_responder.sv
// Bench for the mock LCE responder: vector table plus handshake/error/reset sequences.
module tb_bp_me_nonsynth_mock_lce_responder;
    import bp_me_nonsynth_pkg::*;

    logic               clk = 1'b0;
    logic               rst_n;
    logic [3:0]         lce_id;
    bp_lce_cmd_s        cmd;
    logic               cmd_v;
    logic               yumi;
    bp_lce_cce_resp_s   resp;
    logic               resp_v;
    logic               ready;
    logic               error;
    logic [31:0]        count;

    int total = 0;
    int bad   = 0;

    typedef struct {
        bp_lce_cce_resp_type_e msg;
        bp_mem_size_e          size;
        logic [39:0]           addr;
        logic [3:0]            src;
        logic [3:0]            dst;
        logic [511:0]          data;
    } exp_t;

    typedef struct {
        bp_lce_cmd_type_e      mt;
        logic [5:0]            set;
        logic [2:0]            way;
        bp_coh_states_e        st;
        logic [27:0]           tag;
        logic [3:0]            src;
        logic [3:0]            dst;
        logic [7:0]            pat;
        logic                  has_resp;
        bp_lce_cce_resp_type_e rmsg;
        logic                  wb;
        logic [7:0]            rpat;
    } vec_t;

    exp_t sb[$];
    vec_t tbl [16];

    always #5 clk = ~clk;

    bp_me_nonsynth_mock_lce_responder dut (
        .clk_i            (clk),
        .reset_n_i        (rst_n),
        .lce_id_i         (lce_id),
        .lce_cmd_i        (cmd),
        .lce_cmd_v_i      (cmd_v),
        .lce_cmd_yumi_o   (yumi),
        .lce_resp_o       (resp),
        .lce_resp_v_o     (resp_v),
        .lce_resp_ready_i (ready),
        .error_o          (error),
        .cmd_count_o      (count)
    );

    task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [39:0] mk_addr(input logic [27:0] tag, input logic [5:0] set);
        return {tag, set, 6'b0};
    endfunction

    function automatic vec_t mkv(input bp_lce_cmd_type_e mt, input logic [5:0] set, input logic [2:0] way,
                                 input bp_coh_states_e st, input logic [27:0] tag, input logic [3:0] src,
                                 input logic [3:0] dst, input logic [7:0] pat, input logic has_resp,
                                 input bp_lce_cce_resp_type_e rmsg, input logic wb, input logic [7:0] rpat);
        vec_t v;
        v.mt = mt; v.set = set; v.way = way; v.st = st; v.tag = tag; v.src = src; v.dst = dst;
        v.pat = pat; v.has_resp = has_resp; v.rmsg = rmsg; v.wb = wb; v.rpat = rpat;
        return v;
    endfunction

    // Response monitor: every handshake pops one expected response
    always @(negedge clk) begin : mon
        exp_t e;
        if (rst_n && resp_v && ready) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_resp: got msg %0d expected no response", resp.header.msg_type);
            end else begin
                e = sb.pop_front();
                chk("resp_msg",  512'(resp.header.msg_type), 512'(e.msg));
                chk("resp_size", 512'(resp.header.size),     512'(e.size));
                chk("resp_addr", 512'(resp.header.addr),     512'(e.addr));
                chk("resp_src",  512'(resp.header.src_id),   512'(e.src));
                chk("resp_dst",  512'(resp.header.dst_id),   512'(e.dst));
                chk("resp_data", resp.data,                  e.data);
            end
        end
    end

    // Present one command until consumed; queue its expected response
    task automatic send(input vec_t v, output int waited);
        bp_lce_cmd_s c;
        exp_t        e;
        logic        got;
        logic [7:0]  rp;
        c = '0;
        c.header.msg_type = v.mt;
        c.header.way_id   = v.way;
        c.header.state    = v.st;
        c.header.addr     = mk_addr(v.tag, v.set);
        c.header.src_id   = v.src;
        c.header.dst_id   = v.dst;
        c.data            = {64{v.pat}};
        got    = 1'b0;
        waited = 0;
        @(negedge clk);
        cmd   = c;
        cmd_v = 1'b1;
        for (int i = 0; i < 20; i++) begin
            #1;
            if (yumi) begin
                got = 1'b1;
                break;
            end
            waited++;
            @(negedge clk);
        end
        chk("yumi_seen", 512'(got), 512'(1));
        if (got && v.has_resp) begin
            rp     = v.rpat;
            e.msg  = v.rmsg;
            e.size = v.wb ? e_size_64B : e_size_1B;
            e.addr = mk_addr(v.tag, v.set);
            e.src  = lce_id;
            e.dst  = v.src;
            e.data = v.wb ? {64{rp}} : 512'(0);
            sb.push_back(e);
        end
        @(posedge clk);
        #1 cmd_v = 1'b0;
    endtask

    // Wait, bounded, until all expected responses have been seen
    task automatic drain();
        logic done;
        done = 1'b0;
        for (int i = 0; i < 60 && !done; i++) begin
            @(negedge clk);
            #2;
            if (sb.size() == 0 && !resp_v) done = 1'b1;
        end
        chk("drain", 512'(done), 512'(1));
    endtask

    initial begin : main
        int w;
        vec_t v;
        bp_lce_cce_resp_s snap;

        rst_n  = 1'b0;
        cmd    = '0;
        cmd_v  = 1'b0;
        ready  = 1'b1;
        lce_id = 4'd1;

        tbl[0]  = mkv(e_lce_cmd_sync,           6'd0,  3'd0, e_COH_I, 28'h0,       4'd0, 4'd1, 8'h00, 1'b1, e_lce_cce_sync_ack,     1'b0, 8'h00);
        tbl[1]  = mkv(e_lce_cmd_data,           6'd3,  3'd2, e_COH_M, 28'h0123456, 4'd0, 4'd1, 8'hA5, 1'b1, e_lce_cce_coh_ack,      1'b0, 8'h00);
        tbl[2]  = mkv(e_lce_cmd_writeback,      6'd3,  3'd2, e_COH_I, 28'h0123456, 4'd0, 4'd1, 8'h00, 1'b1, e_lce_cce_resp_wb,      1'b1, 8'hA5);
        tbl[3]  = mkv(e_lce_cmd_writeback,      6'd3,  3'd2, e_COH_I, 28'h0123456, 4'd0, 4'd1, 8'h00, 1'b1, e_lce_cce_resp_null_wb, 1'b0, 8'h00);
        tbl[4]  = mkv(e_lce_cmd_set_tag,        6'd5,  3'd0, e_COH_S, 28'h00000AB, 4'd0, 4'd1, 8'h00, 1'b1, e_lce_cce_coh_ack,      1'b0, 8'h00);
        tbl[5]  = mkv(e_lce_cmd_invalidate_tag, 6'd5,  3'd0, e_COH_I, 28'h00000AB, 4'd0, 4'd1, 8'h00, 1'b1, e_lce_cce_inv_ack,      1'b0, 8'h00);
        tbl[6]  = mkv(e_lce_cmd_writeback,      6'd5,  3'd0, e_COH_I, 28'h00000AB, 4'd0, 4'd1, 8'h00, 1'b1, e_lce_cce_resp_null_wb, 1'b0, 8'h00);
        tbl[7]  = mkv(e_lce_cmd_data,           6'd7,  3'd1, e_COH_E, 28'h0000777, 4'd3, 4'd1, 8'h3C, 1'b1, e_lce_cce_coh_ack,      1'b0, 8'h00);
        tbl[8]  = mkv(e_lce_cmd_writeback,      6'd7,  3'd1, e_COH_I, 28'h0000777, 4'd3, 4'd1, 8'h00, 1'b1, e_lce_cce_resp_null_wb, 1'b0, 8'h00);
        tbl[9]  = mkv(e_lce_cmd_data,           6'd9,  3'd4, e_COH_M, 28'h0000999, 4'd0, 4'd1, 8'h5A, 1'b1, e_lce_cce_coh_ack,      1'b0, 8'h00);
        tbl[10] = mkv(e_lce_cmd_set_clear,      6'd9,  3'd0, e_COH_I, 28'h0000999, 4'd0, 4'd1, 8'h00, 1'b0, e_lce_cce_sync_ack,     1'b0, 8'h00);
        tbl[11] = mkv(e_lce_cmd_writeback,      6'd9,  3'd4, e_COH_I, 28'h0000999, 4'd0, 4'd1, 8'h00, 1'b1, e_lce_cce_resp_null_wb, 1'b0, 8'h00);
        tbl[12] = mkv(e_lce_cmd_set_tag_wakeup, 6'd10, 3'd3, e_COH_E, 28'h0000010, 4'd0, 4'd1, 8'h00, 1'b0, e_lce_cce_sync_ack,     1'b0, 8'h00);
        tbl[13] = mkv(e_lce_cmd_sync,           6'd0,  3'd0, e_COH_I, 28'h0,       4'd2, 4'd1, 8'h00, 1'b1, e_lce_cce_sync_ack,     1'b0, 8'h00);
        tbl[14] = mkv(e_lce_cmd_data,           6'd63, 3'd7, e_COH_M, 28'hFFFFFFF, 4'd1, 4'd1, 8'hFF, 1'b1, e_lce_cce_coh_ack,      1'b0, 8'h00);
        tbl[15] = mkv(e_lce_cmd_writeback,      6'd63, 3'd7, e_COH_I, 28'hFFFFFFF, 4'd1, 4'd1, 8'h00, 1'b1, e_lce_cce_resp_wb,      1'b1, 8'hFF);

        // Reset values
        #2;
        chk("rst_resp_v", 512'(resp_v), 512'(0));
        chk("rst_yumi",   512'(yumi),   512'(0));
        chk("rst_error",  512'(error),  512'(0));
        chk("rst_count",  512'(count),  512'(0));
        chk("rst_resp",   512'(resp.header), 512'(0));
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // First sync: consumed same cycle, response valid on the next
        v = mkv(e_lce_cmd_sync, 6'd0, 3'd0, e_COH_I, 28'h0, 4'd0, 4'd1, 8'h00, 1'b1, e_lce_cce_sync_ack, 1'b0, 8'h00);
        send(v, w);
        chk("first_yumi_wait", 512'(w), 512'(0));
        chk("first_resp_v",    512'(resp_v), 512'(1));
        chk("first_count",     512'(count),  512'(1));
        drain();

        // Vector table
        for (int i = 0; i < 16; i++) begin
            send(tbl[i], w);
        end
        drain();
        chk("table_count", 512'(count), 512'(17));
        chk("table_error", 512'(error), 512'(0));

        // Backpressure: response held stable, no command consumed
        @(posedge clk);
        #1 ready = 1'b0;
        v = mkv(e_lce_cmd_invalidate_tag, 6'd5, 3'd0, e_COH_I, 28'h00000AB, 4'd0, 4'd1, 8'h00, 1'b1, e_lce_cce_inv_ack, 1'b0, 8'h00);
        send(v, w);
        @(negedge clk);
        cmd = '0;
        cmd.header.msg_type = e_lce_cmd_sync;
        cmd.header.dst_id   = 4'd1;
        cmd_v = 1'b1;
        #1 snap = resp;
        for (int i = 0; i < 4; i++) begin
            chk("bp_resp_v",    512'(resp_v), 512'(1));
            chk("bp_yumi",      512'(yumi),   512'(0));
            chk("bp_resp_hdr",  512'(resp.header), 512'(snap.header));
            chk("bp_resp_data", resp.data, snap.data);
            @(negedge clk);
            #1;
        end
        @(posedge clk);
        #1 ready = 1'b1;
        v = mkv(e_lce_cmd_sync, 6'd0, 3'd0, e_COH_I, 28'h0, 4'd0, 4'd1, 8'h00, 1'b1, e_lce_cce_sync_ack, 1'b0, 8'h00);
        send(v, w);
        drain();
        chk("bp_count", 512'(count), 512'(19));

        // Misaddressed command: consumed, ignored, error sticks
        v = mkv(e_lce_cmd_sync, 6'd0, 3'd0, e_COH_I, 28'h0, 4'd0, 4'd2, 8'h00, 1'b0, e_lce_cce_sync_ack, 1'b0, 8'h00);
        send(v, w);
        chk("dst_error", 512'(error), 512'(1));
        chk("dst_count", 512'(count), 512'(20));
        repeat (3) @(negedge clk);
        chk("dst_no_resp", 512'(resp_v), 512'(0));
        v = mkv(e_lce_cmd_sync, 6'd0, 3'd0, e_COH_I, 28'h0, 4'd0, 4'd1, 8'h00, 1'b1, e_lce_cce_sync_ack, 1'b0, 8'h00);
        send(v, w);
        drain();
        chk("error_sticky", 512'(error), 512'(1));

        // Reset during a pending response
        v = mkv(e_lce_cmd_data, 6'd20, 3'd5, e_COH_M, 28'h0000020, 4'd0, 4'd1, 8'h77, 1'b1, e_lce_cce_coh_ack, 1'b0, 8'h00);
        send(v, w);
        drain();
        @(posedge clk);
        #1 ready = 1'b0;
        v = mkv(e_lce_cmd_sync, 6'd0, 3'd0, e_COH_I, 28'h0, 4'd0, 4'd1, 8'h00, 1'b1, e_lce_cce_sync_ack, 1'b0, 8'h00);
        send(v, w);
        chk("pre_rst_resp_v", 512'(resp_v), 512'(1));
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_resp_v", 512'(resp_v), 512'(0));
        chk("mid_rst_count",  512'(count),  512'(0));
        chk("mid_rst_error",  512'(error),  512'(0));
        sb.delete();
        @(posedge clk);
        #1 ready = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;

        // Unknown command type flags an error without a response
        v = mkv(bp_lce_cmd_type_e'(4'hF), 6'd1, 3'd0, e_COH_I, 28'h0, 4'd0, 4'd1, 8'h00, 1'b0, e_lce_cce_sync_ack, 1'b0, 8'h00);
        send(v, w);
        chk("unk_error", 512'(error), 512'(1));
        chk("unk_count", 512'(count), 512'(1));

        // Reset cleared the dirty line
        v = mkv(e_lce_cmd_writeback, 6'd20, 3'd5, e_COH_I, 28'h0000020, 4'd0, 4'd1, 8'h00, 1'b1, e_lce_cce_resp_null_wb, 1'b0, 8'h00);
        send(v, w);
        drain();
        chk("end_count", 512'(count), 512'(2));
        chk("sb_empty",  512'(sb.size()), 512'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/bp_me_nonsynth_mock_lce_responder.md
Name: bp_me_nonsynth_mock_lce_responder

Overview:
Non-synthesizable mock LCE that sits on the CCE-to-LCE command channel in ME unit benches in place of a real cache. It consumes LCE commands and keeps a small tag/state/data shadow array. It returns the protocol-correct LCE response on the response channel (sync_ack, inv_ack, coh_ack, resp_wb, resp_null_wb). It is the responder counterpart to the passive LCE tracer, so CCE benches can run without a full I/D cache.

Parameters:
bp_params_p, e_bp_half_core_cfg, processor config; supplies paddr/lce/cce id widths, lce_assoc_p, cce_block_width_p
sets_p, 64, number of sets in shadow array
assoc_p, 8, ways per set (must equal lce_assoc_p)
block_width_p, 512, cache block bits (must equal cce_block_width_p)

Ports:
clk_i  in  1  clock
reset_n_i  in  1  reset; asynchronous, active-low
lce_id_i  in  lce_id_width_p  this LCE's id; static after reset
lce_cmd_i  in  lce_cmd_width_lp  bp_lce_cmd_s from CCE
lce_cmd_v_i  in  1  command valid
lce_cmd_yumi_o  out  1  command consumed this cycle (valid->yumi)
lce_resp_o  out  lce_cce_resp_width_lp  bp_lce_cce_resp_s to CCE
lce_resp_v_o  out  1  response valid
lce_resp_ready_i  in  1  CCE ready (ready->valid)
error_o  out  1  sticky protocol error
cmd_count_o  out  32  commands consumed since reset

Behaviour:
- Reset (reset_n_i low, asynchronous): state e_ready. lce_resp_v_o=0, lce_cmd_yumi_o=0, error_o=0, cmd_count_o=0. All shadow states = e_COH_I, dirty=0, tags=0. lce_resp_o holds 0.
- FSM states: e_ready, e_send.
- e_ready:
  - lce_cmd_yumi_o = lce_cmd_v_i (combinational).
  - On consume: cmd_count_o+1 (wraps at 2^32). Set = addr[block_offset+:lg_sets]. Way = header.way_id.
- Per msg_type on consume:
  - e_lce_cmd_sync -> queue sync_ack.
  - e_lce_cmd_set_clear -> all ways of set to I, dirty=0; no response.
  - e_lce_cmd_invalidate_tag -> way state I, dirty=0; queue inv_ack.
  - e_lce_cmd_set_tag -> write tag, state; queue coh_ack.
  - e_lce_cmd_set_tag_wakeup -> write tag, state; no response.
  - e_lce_cmd_data -> write tag, state, data; dirty = (state==e_COH_M); queue coh_ack.
  - e_lce_cmd_writeback:
    - dirty -> queue resp_wb with stored block; dirty=0.
    - clean -> queue resp_null_wb with data 0.
  - Any other type -> error_o=1, no array update, no response.
  - header.dst_id != lce_id_i -> error_o=1, command consumed, ignored.
- Queued response: header.src_id=lce_id_i, dst_id=cmd src_id, addr=cmd addr. Size = block size for resp_wb, else 0. Registered; goes to e_send.
- e_send:
  - lce_resp_v_o=1, lce_resp_o stable until lce_resp_ready_i seen high; then back to e_ready next cycle.
  - lce_cmd_yumi_o=0 throughout, so at most one response outstanding.
- Latency: command consumed cycle N -> lce_resp_v_o high cycle N+1. Back-to-back responding commands: one per 2 cycles minimum (ready held high).
- Array write on consume is visible to a command consumed the following cycle.
- Reset mid-e_send: response dropped, valid low immediately.
- error_o is sticky until reset.

Decomposition:
- Shared package (bp_me_nonsynth_pkg): mock state enum {e_ready, e_send}, shadow entry struct {tag, state, dirty}.
- Message enums and structs come from bp_common_pkg via the lce_cce_if macros.
- One sub-module: bp_me_nonsynth_mock_lce_array. Holds sets_p x assoc_p tag/state/dirty/data. One write port, set-clear port and combinational read. Async active-low reset clears state/dirty.

Test Plan:
- sync cmd src cce 0, lce_id_i=1, ready high -> yumi same cycle; next cycle resp_v=1, msg sync_ack, dst 0, src 1; cmd_count_o=1.
- data cmd set 3 way 2 state M, data 0xA5 pattern; then writeback set 3 way 2 -> coh_ack; then resp_wb with data 0xA5 pattern, size = block. Second writeback to same line -> resp_null_wb.
- set_tag set 5 way 0 state S; invalidate_tag same line; writeback -> coh_ack, inv_ack, then resp_null_wb.
- invalidate with lce_resp_ready_i low 4 cycles -> resp_v and resp payload stable 4 cycles; lce_cmd_yumi_o=0 despite cmd_v=1; accepted cycle 5.
- cmd with dst_id=2 while lce_id_i=1 -> consumed, no resp_v, error_o=1 and stays 1.
- reset_n_i dropped while resp_v=1 -> resp_v=0 and cmd_count_o=0 immediately, before any clock edge.
